// File: rtl/rca_seq_ctrl.sv
// Chunk-serial ripple-carry adder: one CHUNK-bit slice per clock, LS chunk first,
// with valid/ready on both sides. Define RCA_SEQ_CTRL_SUB_EN to add the subtract mode (port sub).
module rca_seq_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef RCA_SEQ_CTRL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CMASK    = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic              sub_c;
  logic              accept_c, step_c, last_c;
  logic [31:0]       shamt_c;
  logic [CHUNK-1:0]  a_chunk_c, b_chunk_c, slice_sum_c;
  logic              slice_cout_c, ripple_c;

`ifdef RCA_SEQ_CTRL_SUB_EN
  assign sub_c = sub;
`else
  assign sub_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_n = RUN;
      RUN:     if (idx_q == LAST_IDX)    state_n = DONE;
      DONE:    if (out_ready)            state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: accept_c = in_valid && in_ready;
      RUN: begin
        step_c = 1'b1;
        last_c = (idx_q == LAST_IDX);
      end
      default: ;
    endcase
  end

  // CHUNK-bit ripple-carry slice on the chunk selected by idx
  always_comb begin
    shamt_c      = 32'(idx_q) * CHUNK;
    a_chunk_c    = CHUNK'(a_q >> shamt_c);
    b_chunk_c    = CHUNK'(b_q >> shamt_c);
    slice_sum_c  = '0;
    ripple_c     = carry_q;
    for (int i = 0; i < int'(CHUNK); i++) begin
      slice_sum_c[i] = a_chunk_c[i] ^ b_chunk_c[i] ^ ripple_c;
      ripple_c       = (a_chunk_c[i] & b_chunk_c[i]) | (ripple_c & (a_chunk_c[i] ^ b_chunk_c[i]));
    end
    slice_cout_c = ripple_c;
  end

  // Operand/carry/index registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
      if (accept_c) begin
        // Subtraction is a + ~b + 1: invert b once at capture, seed the carry with 1
        a_q     <= a;
        b_q     <= sub_c ? ~b : b;
        carry_q <= sub_c;
        idx_q   <= '0;
      end else if (step_c) begin
        sum     <= (sum & ~(CMASK << shamt_c)) | (WIDTH'(slice_sum_c) << shamt_c);
        carry_q <= slice_cout_c;
        idx_q   <= last_c ? '0 : idx_q + IDXW'(1);
        if (last_c) carry_out <= slice_cout_c;
      end
    end
  end

endmodule
